dmux4way_reg: RTL and testbench

//  Registered 1-to-4 word demultiplexer: the routing counterpart to the bitwise

---
 rtl/dmux4way_reg.sv | 91 +++++++++
 tb/tb_dmux4way_reg.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/dmux4way_reg.sv
// Registered 1-to-4 word demux with one holding register per channel; 1-clock in-to-out latency.
// Backpressure: the input stalls only when the selected channel is full and not draining.
module dmux4way_reg #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [1:0]         in_sel,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [4*WIDTH-1:0] out_data,
  output logic [3:0]         out_valid,
  input  logic [3:0]         out_ready,
  output logic [CNT_W-1:0]   deliv_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [WIDTH-1:0] data_q [4];
  logic [3:0]       valid_q;
  logic [CNT_W-1:0] cnt_q;

  logic [3:0]       drain;
  logic [3:0]       load;
  logic             accept;
  logic [2:0]       n_drain;
  logic [CNT_W:0]   cnt_sum;

  // Ready looks only at the selected channel, never at in_valid.
  assign in_ready = ~valid_q[in_sel] | out_ready[in_sel];
  assign accept   = in_valid & in_ready;
  assign drain    = valid_q & out_ready;

  always_comb begin
    load = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      load[k] = accept & (in_sel == 2'(k));
    end
  end

  always_comb begin
    n_drain = 3'd0;
    for (int k = 0; k < 4; k++) begin
      n_drain = n_drain + 3'(drain[k]);
    end
  end

  assign cnt_sum = {1'b0, cnt_q} + (CNT_W+1)'(n_drain);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 4'b0000;
      for (int k = 0; k < 4; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        // A reload wins over a drain so a same-cycle refill stays full.
        if (load[k]) begin
          valid_q[k] <= 1'b1;
          data_q[k]  <= in_data;
        end else if (drain[k]) begin
          valid_q[k] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (cnt_sum[CNT_W]) begin
      cnt_q <= CNT_MAX;
    end else begin
      cnt_q <= cnt_sum[CNT_W-1:0];
    end
  end

  always_comb begin
    out_data = '0;
    for (int k = 0; k < 4; k++) begin
      out_data[k*WIDTH +: WIDTH] = data_q[k];
    end
  end

  assign out_valid = valid_q;
  assign deliv_cnt = cnt_q;

endmodule

// File: tb/tb_dmux4way_reg.sv
// Directed bench for dmux4way_reg: reset, routing, backpressure, refill, parallel drain, saturation.
module tb_dmux4way_reg;

  logic        clk;
  logic        rst;
  logic [15:0] in_data;
  logic [1:0]  in_sel;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] out_data;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [7:0]  deliv_cnt;

  int n_pass;
  int n_total;

  dmux4way_reg #(.WIDTH(16), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .deliv_cnt (deliv_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] ch(input int k);
    return out_data[k*16 +: 16];
  endfunction

  task automatic send(input logic [1:0] sel, input logic [15:0] dat);
    in_valid = 1'b1;
    in_sel   = sel;
    in_data  = dat;
    cyc();
    in_valid = 1'b0;
  endtask

  initial begin
    n_pass    = 0;
    n_total   = 0;
    rst       = 1'b1;
    in_data   = '0;
    in_sel    = '0;
    in_valid  = 1'b0;
    out_ready = 4'b0000;
    cyc();
    cyc();
    rst = 1'b0;
    cyc();
    chk("reset_valid", 64'(out_valid), 64'h0);
    chk("reset_cnt", 64'(deliv_cnt), 64'h0);

    // Build up some state, then reset asynchronously mid-cycle.
    send(2'd0, 16'hBEEF);
    out_ready = 4'b0001;
    cyc();
    out_ready = 4'b0000;
    send(2'd1, 16'hCAFE);
    chk("pre_rst_valid", 64'(out_valid), 64'h2);
    chk("pre_rst_cnt", 64'(deliv_cnt), 64'h1);
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", 64'(out_valid), 64'h0);
    chk("async_rst_data", out_data, 64'h0);
    chk("async_rst_cnt", 64'(deliv_cnt), 64'h0);
    cyc();
    rst = 1'b0;
    cyc();

    // Single route through channel 2.
    out_ready = 4'b1111;
    in_valid  = 1'b1;
    in_sel    = 2'd2;
    in_data   = 16'hA5A5;
    #1;
    chk("route_in_ready", 64'(in_ready), 64'h1);
    cyc();
    in_valid = 1'b0;
    chk("route_valid", 64'(out_valid), 64'h4);
    chk("route_data", 64'(ch(2)), 64'hA5A5);
    chk("route_cnt0", 64'(deliv_cnt), 64'h0);
    cyc();
    chk("route_drained", 64'(out_valid), 64'h0);
    chk("route_cnt1", 64'(deliv_cnt), 64'h1);

    // Backpressure on channel 1 must not block channel 3.
    out_ready = 4'b0000;
    send(2'd1, 16'h1111);
    chk("bp_ch1_valid", 64'(out_valid), 64'h2);
    in_sel  = 2'd1;
    in_data = 16'h2222;
    #1;
    chk("bp_ready_novalid", 64'(in_ready), 64'h0);
    in_valid = 1'b1;
    #1;
    chk("bp_ready_stall", 64'(in_ready), 64'h0);
    cyc();
    chk("bp_ch1_kept", 64'(ch(1)), 64'h1111);
    chk("bp_ch1_still", 64'(out_valid), 64'h2);
    in_sel  = 2'd3;
    in_data = 16'h3333;
    #1;
    chk("bp_ch3_ready", 64'(in_ready), 64'h1);
    cyc();
    in_valid = 1'b0;
    chk("bp_ch3_valid", 64'(out_valid), 64'hA);
    chk("bp_ch3_data", 64'(ch(3)), 64'h3333);
    chk("bp_ch1_final", 64'(ch(1)), 64'h1111);
    out_ready = 4'b1111;
    cyc();
    out_ready = 4'b0000;
    chk("bp_drain_valid", 64'(out_valid), 64'h0);
    chk("bp_drain_cnt", 64'(deliv_cnt), 64'h3);

    // Same-cycle drain and refill on channel 0.
    send(2'd0, 16'h0001);
    chk("refill_pre", 64'(out_valid), 64'h1);
    out_ready = 4'b0001;
    in_valid  = 1'b1;
    in_sel    = 2'd0;
    in_data   = 16'h0002;
    #1;
    chk("refill_ready", 64'(in_ready), 64'h1);
    cyc();
    in_valid  = 1'b0;
    out_ready = 4'b0000;
    chk("refill_valid", 64'(out_valid), 64'h1);
    chk("refill_data", 64'(ch(0)), 64'h0002);
    chk("refill_cnt", 64'(deliv_cnt), 64'h4);
    out_ready = 4'b0001;
    cyc();
    out_ready = 4'b0000;
    chk("refill_drain_cnt", 64'(deliv_cnt), 64'h5);
    chk("empty_holds_data", 64'(ch(0)), 64'h0002);

    // Parallel drain of all four channels.
    send(2'd0, 16'h0010);
    send(2'd1, 16'h0020);
    send(2'd2, 16'h0030);
    send(2'd3, 16'h0040);
    chk("par_valid", 64'(out_valid), 64'hF);
    chk("par_data", out_data, 64'h0040_0030_0020_0010);
    out_ready = 4'b1111;
    cyc();
    out_ready = 4'b0000;
    chk("par_drained", 64'(out_valid), 64'h0);
    chk("par_cnt", 64'(deliv_cnt), 64'h9);

    // Stream 245 words through channel 0 to bring the counter to 254.
    out_ready = 4'b0001;
    in_valid  = 1'b1;
    in_sel    = 2'd0;
    in_data   = 16'h5A5A;
    cyc();
    repeat (244) cyc();
    in_valid = 1'b0;
    cyc();
    out_ready = 4'b0000;
    chk("sat_pre_cnt", 64'(deliv_cnt), 64'd254);
    chk("sat_pre_valid", 64'(out_valid), 64'h0);
    send(2'd0, 16'h00A0);
    send(2'd1, 16'h00A1);
    send(2'd2, 16'h00A2);
    chk("sat_hold_cnt", 64'(deliv_cnt), 64'd254);
    out_ready = 4'b0111;
    cyc();
    out_ready = 4'b0000;
    chk("sat_cnt", 64'(deliv_cnt), 64'd255);
    send(2'd3, 16'h00A3);
    out_ready = 4'b1000;
    cyc();
    out_ready = 4'b0000;
    chk("sat_stays", 64'(deliv_cnt), 64'd255);
    chk("sat_valid", 64'(out_valid), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
